inst_prefetch_queue: RTL and testbench

Instruction fetch front-end that sits directly upstream of the single-cycle CPU core. It owns the fetch PC and issues word-addressed read requests to a variable-latency instruction memory port. Returned instructions are buffered in an in-order FIFO and presented to the core's decode stage over a valid/ready handshake. On a taken branch or jump, the core drives a redirect; the queue flushes its contents and discards responses still in flight.

---
 rtl/inst_prefetch_queue.sv | 97 +++++++++
 tb/tb_inst_prefetch_queue.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/inst_prefetch_queue.sv
// inst_prefetch_queue: instruction fetch front-end that issues word-addressed reads,
// buffers in-order responses in a FIFO and hands them to decode over valid/ready.
// Ports:
//   Clk, Rst                      clock, asynchronous active-low reset
//   Redirect, Redirect_Pc         flush queue and restart fetch at Redirect_Pc
//   Mem_Req_Valid/Ready/Addr      fetch request channel (word address)
//   Mem_Rsp_Valid/Data            in-order read responses, no backpressure
//   Inst_Valid/Ready, Inst, Inst_Pc   head of the FIFO towards decode
//   Occupancy                     number of buffered instructions
module inst_prefetch_queue #(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      Redirect,
    input  logic [DATA_W-1:0]         Redirect_Pc,
    output logic                      Mem_Req_Valid,
    input  logic                      Mem_Req_Ready,
    output logic [DATA_W-1:0]         Mem_Req_Addr,
    input  logic                      Mem_Rsp_Valid,
    input  logic [DATA_W-1:0]         Mem_Rsp_Data,
    output logic                      Inst_Valid,
    input  logic                      Inst_Ready,
    output logic [DATA_W-1:0]         Inst,
    output logic [DATA_W-1:0]         Inst_Pc,
    output logic [$clog2(DEPTH):0]    Occupancy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

    logic [DATA_W-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]     count_q, count_d, outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] inst_q [DEPTH];
    logic [DATA_W-1:0] inst_d [DEPTH];
    logic [DATA_W-1:0] pc_q [DEPTH];
    logic [DATA_W-1:0] pc_d [DEPTH];
    logic              fire, rsp, push, pop;

    // Credit check on registered state only: buffered plus in-flight never exceeds DEPTH.
    assign Mem_Req_Valid = Rst && !Redirect && (({1'b0, count_q} + {1'b0, outstanding_q}) < DEPTH_L);
    assign Mem_Req_Addr  = fetch_pc_q;
    assign fire          = Mem_Req_Valid && Mem_Req_Ready;
    assign rsp           = Mem_Rsp_Valid && (outstanding_q != '0);
    assign push          = rsp && (drop_cnt_q == '0) && !Redirect;
    assign pop           = (count_q != '0) && Inst_Ready && !Redirect;
    assign Inst_Valid    = count_q != '0;
    assign Inst          = inst_q[rd_ptr_q];
    assign Inst_Pc       = pc_q[rd_ptr_q];
    assign Occupancy     = count_q;

    always_comb begin
        fetch_pc_d    = Redirect ? Redirect_Pc : fetch_pc_q + DATA_W'(fire);
        rsp_pc_d      = Redirect ? Redirect_Pc : rsp_pc_q + DATA_W'(push);
        outstanding_d = outstanding_q + CW'(fire) - CW'(rsp);
        // Responses already marked for dropping are a subset of those in flight, so on
        // a redirect every remaining in-flight response is stale; rsp implies outstanding>0.
        drop_cnt_d    = Redirect ? outstanding_q - CW'(rsp)
                                 : drop_cnt_q - CW'(rsp && (drop_cnt_q != '0));
        count_d       = Redirect ? '0 : count_q + CW'(push) - CW'(pop);
        wr_ptr_d      = Redirect ? rd_ptr_q : wr_ptr_q + PW'(push);
        rd_ptr_d      = rd_ptr_q + PW'(pop);
        inst_d        = inst_q;
        pc_d          = pc_q;
        if (push) begin
            inst_d[wr_ptr_q] = Mem_Rsp_Data;
            pc_d[wr_ptr_q]   = rsp_pc_q;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            inst_q        <= '{default: '0};
            pc_q          <= '{default: '0};
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            inst_q        <= inst_d;
            pc_q          <= pc_d;
        end
    end
endmodule

// File: tb/tb_inst_prefetch_queue.sv
// tb_inst_prefetch_queue: scoreboard bench with a variable-latency in-order memory model.
module tb_inst_prefetch_queue;
    localparam int          W        = 32;
    localparam int          DEPTH    = 4;
    localparam logic [W-1:0] RESET_PC = '0;

    typedef struct {
        logic [W-1:0] addr;
        int           epoch;
        int           due;
    } fl_t;

    typedef struct {
        logic [W-1:0] pc;
        logic [W-1:0] inst;
    } ex_t;

    logic         Clk, Rst, Redirect, Mem_Req_Valid, Mem_Req_Ready, Mem_Rsp_Valid;
    logic         Inst_Valid, Inst_Ready;
    logic [W-1:0] Redirect_Pc, Mem_Req_Addr, Mem_Rsp_Data, Inst, Inst_Pc;
    logic [2:0]   Occupancy;

    inst_prefetch_queue #(.DATA_W(W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .Clk(Clk), .Rst(Rst), .Redirect(Redirect), .Redirect_Pc(Redirect_Pc),
        .Mem_Req_Valid(Mem_Req_Valid), .Mem_Req_Ready(Mem_Req_Ready), .Mem_Req_Addr(Mem_Req_Addr),
        .Mem_Rsp_Valid(Mem_Rsp_Valid), .Mem_Rsp_Data(Mem_Rsp_Data),
        .Inst_Valid(Inst_Valid), .Inst_Ready(Inst_Ready), .Inst(Inst), .Inst_Pc(Inst_Pc),
        .Occupancy(Occupancy)
    );

    fl_t          inflight[$];
    ex_t          exp_q[$];
    logic [W-1:0] model_pc, redir_pc;
    bit           redir_pend, spurious, last_pop;
    int           epoch, cyc, lat, n_pass, n_total;

    initial begin
        Clk = 0;
        forever #5 Clk = ~Clk;
    end

    function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
        return (a * 32'h0100_0193) ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    // One clock cycle: drive inputs at negedge, check outputs, advance the model.
    task automatic step(input logic mrdy, input logic irdy, input logic redir, input logic [W-1:0] rpc);
        ex_t  e;
        fl_t  f;
        logic rsp, exp_rv, pop;
        @(negedge Clk);
        Mem_Req_Ready = mrdy;
        Inst_Ready    = irdy;
        Redirect      = redir;
        Redirect_Pc   = rpc;
        rsp           = inflight.size() != 0 && inflight[0].due <= cyc;
        Mem_Rsp_Valid = rsp || spurious;
        Mem_Rsp_Data  = rsp ? mem_word(inflight[0].addr) : W'($urandom);
        #1;
        exp_rv = (exp_q.size() + inflight.size() < DEPTH) && !redir;
        pop    = exp_q.size() != 0 && irdy && !redir;
        check("occupancy", 32'(Occupancy), exp_q.size());
        check("inst_valid", 32'(Inst_Valid), 32'(exp_q.size() != 0));
        check("req_valid", 32'(Mem_Req_Valid), 32'(exp_rv));
        check("req_addr", Mem_Req_Addr, model_pc);
        last_pop = pop;
        if (pop) begin
            e = exp_q.pop_front();
            check("inst_pc", Inst_Pc, e.pc);
            check("inst", Inst, e.inst);
            if (redir_pend) check("restart_pc", Inst_Pc, redir_pc);
            redir_pend = 0;
        end
        if (exp_rv && mrdy) begin
            inflight.push_back('{model_pc, epoch, cyc + lat});
            model_pc++;
        end
        if (rsp) begin
            f = inflight.pop_front();
            if (f.epoch == epoch && !redir) exp_q.push_back('{f.addr, mem_word(f.addr)});
        end
        if (redir) begin
            exp_q.delete();
            epoch++;
            model_pc   = rpc;
            redir_pc   = rpc;
            redir_pend = 1;
        end
        cyc++;
    endtask

    task automatic async_reset();
        @(negedge Clk);
        #2;
        Rst = 0;
        #1;
        check("rst_req_valid", 32'(Mem_Req_Valid), 0);
        check("rst_req_addr", Mem_Req_Addr, RESET_PC);
        check("rst_inst_valid", 32'(Inst_Valid), 0);
        check("rst_inst", Inst, 0);
        check("rst_inst_pc", Inst_Pc, 0);
        check("rst_occupancy", 32'(Occupancy), 0);
        Redirect      = 0;
        Mem_Req_Ready = 0;
        Inst_Ready    = 0;
        Mem_Rsp_Valid = 0;
        inflight.delete();
        exp_q.delete();
        epoch++;
        model_pc   = RESET_PC;
        redir_pc   = RESET_PC;
        redir_pend = 1;
        @(negedge Clk);
        Rst = 1;
    endtask

    initial begin
        Rst = 0; Redirect = 0; Redirect_Pc = '0; Mem_Req_Ready = 0; Inst_Ready = 0;
        Mem_Rsp_Valid = 0; Mem_Rsp_Data = '0;
        n_pass = 0; n_total = 0; epoch = 0; cyc = 0; lat = 1; spurious = 0;
        async_reset();
        // 1-cycle memory, consumer always ready: one instruction per cycle from the third cycle
        for (int i = 0; i < 30; i++) begin
            step(1, 1, 0, '0);
            if (i >= 2) check("throughput", 32'(last_pop), 1);
        end
        // consumer stalled: exactly DEPTH fetches, then drain and resume
        async_reset();
        for (int i = 0; i < 10; i++) step(1, 0, 0, '0);
        check("full_next_addr", model_pc, 32'd4);
        for (int i = 0; i < 12; i++) step(1, 1, 0, '0);
        // 3-cycle memory with responses in flight, redirect to 0x40
        lat = 3;
        for (int i = 0; i < 40 && inflight.size() < 2; i++) step(1, 1, 0, '0);
        check("c_setup", 32'(inflight.size() >= 2), 1);
        step(1, 1, 1, 32'h40);
        for (int i = 0; i < 15; i++) step(1, 1, 0, '0);
        // redirect on the same cycle as a response with two buffered entries
        lat = 2;
        for (int i = 0; i < 40 && !(exp_q.size() >= 2 && inflight.size() != 0 && inflight[0].due <= cyc); i++)
            step(1, 0, 0, '0);
        check("d_setup", 32'(exp_q.size() >= 2 && inflight.size() != 0), 1);
        step(1, 1, 1, 32'h100);
        for (int i = 0; i < 12; i++) step(1, 1, 0, '0);
        // memory stalls for 5 cycles: request held with stable address
        for (int i = 0; i < 5; i++) step(0, 1, 0, '0);
        step(1, 1, 0, '0);
        for (int i = 0; i < 8; i++) step(1, 1, 0, '0);
        // back-to-back redirects
        lat = 3;
        for (int i = 0; i < 4; i++) step(1, 1, 0, '0);
        step(1, 1, 1, 32'h200);
        step(1, 1, 1, 32'h300);
        for (int i = 0; i < 15; i++) step(1, 1, 0, '0);
        // reset mid-stream, then a spurious late response
        lat = 4;
        for (int i = 0; i < 40 && !(exp_q.size() >= 2 && inflight.size() >= 1); i++) step(1, 0, 0, '0);
        check("r_setup", 32'(exp_q.size() >= 2 && inflight.size() >= 1), 1);
        async_reset();
        spurious = 1;
        step(0, 0, 0, '0);
        spurious = 0;
        step(0, 0, 0, '0);
        for (int i = 0; i < 15; i++) step(1, 1, 0, '0);
        // randomized traffic including a wrap of the fetch PC
        for (int i = 0; i < 1500; i++) begin
            if (i % 200 == 0) lat = $urandom_range(1, 4);
            if (i == 700) step(1, 1, 1, 32'hFFFF_FFFE);
            else step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 39) == 0, W'($urandom));
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
